multicycle_ctrl: RTL and testbench

Parametrised multicycle control unit for the four-instruction-class datapath: data-processing register, data-processing immediate, load/store and branch. It uses the same 2-bit op, I-bit (funct5) and L-bit (funct0) encoding as the single-cycle main decoder, but sequences each instruction over several cycles. It adds a memory-ready handshake with timeout, condition gating of all architectural writes, and optional performance counters. It sits between the instruction register and the shared datapath and memory port.

---
 rtl/multicycle_ctrl_pkg.sv | 64 ++++++
 rtl/multicycle_ctrl_mem_wait_timer.sv | 30 +++
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction
// classes, datapath mux selects and the imm_src/reg_src pairs that match the
// single-cycle main decoder.
package multicycle_ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECR    = 4'd6;
    localparam logic [3:0] ST_EXECI    = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;

    typedef enum logic [3:0] {
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_MEMADR   = ST_MEMADR,
        S_MEMREAD  = ST_MEMREAD,
        S_MEMWB    = ST_MEMWB,
        S_MEMWRITE = ST_MEMWRITE,
        S_EXECR    = ST_EXECR,
        S_EXECI    = ST_EXECI,
        S_ALUWB    = ST_ALUWB,
        S_BRANCH   = ST_BRANCH
    } state_t;

    localparam logic [1:0] OP_DP      = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b01;
    localparam logic [1:0] OP_BRANCH  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [1:0] SRC_A_RN = 2'b00;
    localparam logic [1:0] SRC_A_PC = 2'b01;

    localparam logic [1:0] SRC_B_RM   = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_DP     = 2'b00;
    localparam logic [1:0] IMM_MEM    = 2'b01;
    localparam logic [1:0] IMM_BRANCH = 2'b10;
    localparam logic [1:0] REG_DP     = 2'b00;
    localparam logic [1:0] REG_MEM    = 2'b10;
    localparam logic [1:0] REG_BRANCH = 2'b01;

    // {imm_src, reg_src} for an instruction class; illegal falls back to DP
    function automatic logic [3:0] src_sel(input logic [1:0] op);
        logic [3:0] sel;
        case (op)
            OP_MEM:    sel = {IMM_MEM, REG_MEM};
            OP_BRANCH: sel = {IMM_BRANCH, REG_BRANCH};
            default:   sel = {IMM_DP, REG_DP};
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait timer: down-counter reloaded with WAIT_MAX-1 on clear, on
// timeout and in reset; each advance decrements it and an advance at zero
// is the WAIT_MAX-th consecutive stall, reported as timeout.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic timeout
);

    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [CW-1:0] LOAD = CW'(WAIT_MAX - 1);

    logic [CW-1:0] remaining;

    assign timeout = advance && (remaining == '0);

    // reload on any restart condition, otherwise count down one per stall
    always_ff @(posedge clk) begin
        if (reset || clear || timeout) begin
            remaining <= LOAD;
        end else if (advance) begin
            remaining <= remaining - CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the DP-reg / DP-imm / load-store / branch
// datapath. Sequences each instruction over several cycles, gates every
// architectural write with cond_ex, and bounds memory waits with a timeout
// that raises a sticky bus_err.
// Optional performance counters are built when MULTICYCLE_CTRL_PERF_EN is
// defined; otherwise the counter ports read 0.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4, wait for mem_ready
// DECODE   | read registers, compute PC+8, dispatch on op
// MEMADR   | compute load/store address Rn + imm
// MEMREAD  | read data memory, wait for mem_ready
// MEMWB    | write loaded data to Rd
// MEMWRITE | write data memory (waits only if cond_ex)
// EXECR    | ALU op with register operand
// EXECI    | ALU op with immediate operand
// ALUWB    | write ALU result to Rd
// BRANCH   | PC <= PC+8 + imm
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic             funct5,
    input  logic             funct0,
    input  logic             cond_ex,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_w,
    output logic             reg_w,
    output logic             adr_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [1:0]       imm_src,
    output logic [1:0]       reg_src,
    output logic             alu_op,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t state, next_state, out_state;
    logic   waiting, advance, timeout, state_change;

    // states that hold for mem_ready; a skipped store does not wait
    always_comb begin
        waiting = (state == S_FETCH) || (state == S_MEMREAD) ||
                  ((state == S_MEMWRITE) && cond_ex);
    end

    assign advance      = waiting && !mem_ready;
    assign state_change = (next_state != state);

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_change),
        .advance (advance),
        .timeout (timeout)
    );

    // next-state logic; timeout and reset both abort to FETCH
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_DP:     next_state = funct5 ? S_EXECI : S_EXECR;
                    OP_MEM:    next_state = S_MEMADR;
                    OP_BRANCH: next_state = S_BRANCH;
                    default:   next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = funct0 ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWRITE: if (!cond_ex || mem_ready) next_state = S_FETCH;
            S_EXECR,
            S_EXECI:    next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
        if (reset || timeout) next_state = S_FETCH;
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // sticky bus error, only reset clears it
    always_ff @(posedge clk) begin
        if (reset)        bus_err <= 1'b0;
        else if (timeout) bus_err <= 1'b1;
    end

    assign out_state = reset ? S_FETCH : state;

    // per-state datapath controls; write enables dropped on reset or timeout
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_RN;
        alu_src_b  = SRC_B_RM;
        result_src = RES_ALUOUT;
        imm_src    = IMM_DP;
        reg_src    = REG_DP;
        alu_op     = 1'b0;
        illegal    = 1'b0;
        case (out_state)
            S_FETCH: begin
                alu_src_a  = SRC_A_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a          = SRC_A_PC;
                alu_src_b          = SRC_B_FOUR;
                result_src         = RES_ALU;
                {imm_src, reg_src} = src_sel(op);
                illegal            = (op == OP_ILLEGAL);
            end
            S_MEMADR:   alu_src_b = SRC_B_IMM;
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_w      = cond_ex;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = cond_ex;
            end
            S_EXECR:    alu_op = 1'b1;
            S_EXECI: begin
                alu_op    = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_ALUWB:    reg_w = cond_ex;
            S_BRANCH: begin
                alu_src_b  = SRC_B_IMM;
                imm_src    = IMM_BRANCH;
                result_src = RES_ALU;
                pc_write   = cond_ex;
            end
            default: ;
        endcase
        if (reset || timeout) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            mem_w    = 1'b0;
            reg_w    = 1'b0;
            illegal  = 1'b0;
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cyc_q, instr_q, stall_q;
    logic             enter_decode;

    assign enter_decode = (state == S_FETCH) && (next_state == S_DECODE);

    // saturating cycle / instruction / stall counters
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q   <= '0;
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            if (cyc_q != CNT_MAX)                   cyc_q   <= cyc_q + CNT_W'(1);
            if (enter_decode && instr_q != CNT_MAX) instr_q <= instr_q + CNT_W'(1);
            if (advance && stall_q != CNT_MAX)      stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cyc_q;
    assign instr_cnt = instr_q;
    assign stall_cnt = stall_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams, checked cycle by cycle against a phase-sequence
// model of each instruction class.
module tb_multicycle_ctrl;

    localparam int CNT_W    = 8;
    localparam int WAIT_MAX = 4;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;
`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int PH_FETCH    = 0;
    localparam int PH_DECODE   = 1;
    localparam int PH_MEMADR   = 2;
    localparam int PH_MEMREAD  = 3;
    localparam int PH_MEMWB    = 4;
    localparam int PH_MEMWRITE = 5;
    localparam int PH_EXECR    = 6;
    localparam int PH_EXECI    = 7;
    localparam int PH_ALUWB    = 8;
    localparam int PH_BRANCH   = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       op = 2'b00;
    logic             funct5 = 1'b0, funct0 = 1'b0, cond_ex = 1'b0, mem_ready = 1'b0;
    logic             pc_write, ir_write, mem_w, reg_w, adr_src, alu_op, illegal, bus_err;
    logic [1:0]       alu_src_a, alu_src_b, result_src, imm_src, reg_src;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt, stall_cnt;
    logic [16:0]      act;

    multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .op(op), .funct5(funct5), .funct0(funct0),
        .cond_ex(cond_ex), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_w(mem_w), .reg_w(reg_w),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src),
        .alu_op(alu_op), .illegal(illegal), .bus_err(bus_err),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign act = {pc_write, ir_write, mem_w, reg_w, adr_src, alu_src_a, alu_src_b,
                  result_src, imm_src, reg_src, alu_op, illegal};

    int tests_run = 0;
    int tests_failed = 0;
    int m_cyc = 0, m_instr = 0, m_stall = 0;
    bit m_bus = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int m);
        if (!PERF) return 32'd0;
        return (m > CNT_SAT) ? 32'(CNT_SAT) : 32'(m);
    endfunction

    // expected control word for one phase, straight from the per-state tables
    function automatic logic [16:0] exp_vec(input int ph, input logic [1:0] o, input logic c,
                                            input logic rdy, input logic rst_i, input logic to);
        logic       pcw, irw, mw, rw, adr, aop, ill;
        logic [1:0] a, b, res, imm, rs;
        int         p;
        {pcw, irw, mw, rw, adr, aop, ill} = '0;
        {a, b, res, imm, rs} = '0;
        p = rst_i ? PH_FETCH : ph;
        case (p)
            PH_FETCH:    begin a = 2'b01; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
            PH_DECODE: begin
                a = 2'b01; b = 2'b10; res = 2'b10;
                if (o == 2'b01) begin imm = 2'b01; rs = 2'b10; end
                if (o == 2'b10) begin imm = 2'b10; rs = 2'b01; end
                ill = (o == 2'b11);
            end
            PH_MEMADR:   b = 2'b01;
            PH_MEMREAD:  adr = 1'b1;
            PH_MEMWB:    begin res = 2'b01; rw = c; end
            PH_MEMWRITE: begin adr = 1'b1; mw = c; end
            PH_EXECR:    aop = 1'b1;
            PH_EXECI:    begin aop = 1'b1; b = 2'b01; end
            PH_ALUWB:    rw = c;
            PH_BRANCH:   begin b = 2'b01; imm = 2'b10; res = 2'b10; pcw = c; end
            default: ;
        endcase
        if (rst_i || to) {pcw, irw, mw, rw, ill} = '0;
        return {pcw, irw, mw, rw, adr, a, b, res, imm, rs, aop, ill};
    endfunction

    // one clock: drive, check mid-cycle, advance, update the model
    task automatic cycle(input int ph, input logic [1:0] o, input logic f5, input logic f0,
                         input logic c, input logic rdy, input logic rst_i, input logic to,
                         input logic adv, input logic dec, input string tag);
        op = o; funct5 = f5; funct0 = f0; cond_ex = c; mem_ready = rdy; reset = rst_i;
        #2;
        check({tag, ":ctl"}, 32'(act), 32'(exp_vec(ph, o, c, rdy, rst_i, to)));
        check({tag, ":bus_err"}, 32'(bus_err), 32'(m_bus));
        check({tag, ":cycle_cnt"}, 32'(cycle_cnt), cnt_exp(m_cyc));
        check({tag, ":instr_cnt"}, 32'(instr_cnt), cnt_exp(m_instr));
        check({tag, ":stall_cnt"}, 32'(stall_cnt), cnt_exp(m_stall));
        @(posedge clk);
        #1;
        if (rst_i) begin
            m_cyc = 0; m_instr = 0; m_stall = 0; m_bus = 1'b0;
        end else begin
            m_cyc++;
            if (dec) m_instr++;
            if (adv) m_stall++;
            if (to)  m_bus = 1'b1;
        end
    endtask

    // a memory-wait phase: 'stalls' cycles of mem_ready=0, then the ready
    // cycle; the WAIT_MAX-th consecutive stall is the timeout
    task automatic wait_phase(input int ph, input logic [1:0] o, input logic f5, input logic f0,
                              input logic c, input int stalls, input string tag, output bit to);
        bit t;
        to = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            t = (i == WAIT_MAX - 1);
            cycle(ph, o, f5, f0, c, 1'b0, 1'b0, t, 1'b1, 1'b0, tag);
            if (t) begin
                to = 1'b1;
                return;
            end
        end
        cycle(ph, o, f5, f0, c, 1'b1, 1'b0, 1'b0, 1'b0, (ph == PH_FETCH), tag);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // full instruction from FETCH back to the next FETCH
    task automatic run_instr(input logic [1:0] o, input logic f5, input logic f0, input logic c,
                             input int sf, input int sm, input string tag);
        bit to;
        wait_phase(PH_FETCH, o, f5, f0, c, sf, tag, to);
        if (to) return;
        cycle(PH_DECODE, o, f5, f0, c, rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, tag);
        case (o)
            2'b00: begin
                cycle(f5 ? PH_EXECI : PH_EXECR, o, f5, f0, c, rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, tag);
                cycle(PH_ALUWB, o, f5, f0, c, rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, tag);
            end
            2'b01: begin
                cycle(PH_MEMADR, o, f5, f0, c, rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, tag);
                if (f0) begin
                    wait_phase(PH_MEMREAD, o, f5, f0, c, sm, tag, to);
                    if (!to) cycle(PH_MEMWB, o, f5, f0, c, rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, tag);
                end else if (c) begin
                    wait_phase(PH_MEMWRITE, o, f5, f0, c, sm, tag, to);
                end else begin
                    cycle(PH_MEMWRITE, o, f5, f0, c, rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, tag);
                end
            end
            2'b10: cycle(PH_BRANCH, o, f5, f0, c, rnd_bit(), 1'b0, 1'b0, 1'b0, 1'b0, tag);
            default: ;
        endcase
    endtask

    task automatic do_reset(input string tag);
        cycle(PH_FETCH, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_reset("reset");
        run_instr(2'b00, 1'b0, 1'b0, 1'b1, 0, 0, "dp_reg");
        run_instr(2'b00, 1'b1, 1'b0, 1'b1, 0, 0, "dp_imm");
        run_instr(2'b00, 1'b0, 1'b0, 1'b0, 0, 0, "dp_nocond");

        do_reset("reset_load");
        run_instr(2'b01, 1'b0, 1'b1, 1'b1, 0, 3, "load_stall");
        check("load_stall_cnt", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);
        run_instr(2'b01, 1'b0, 1'b0, 1'b0, 0, 0, "store_nocond");
        run_instr(2'b01, 1'b0, 1'b0, 1'b1, 2, 1, "store_cond");
        run_instr(2'b10, 1'b0, 1'b0, 1'b1, 0, 0, "branch_taken");
        run_instr(2'b10, 1'b0, 1'b0, 1'b0, 0, 0, "branch_not");
        run_instr(2'b11, 1'b0, 1'b0, 1'b1, 0, 0, "illegal");
        run_instr(2'b00, 1'b0, 1'b0, 1'b1, 1, 0, "after_illegal");

        // reset in the middle of a load stall
        cycle(PH_FETCH,   2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "midrst");
        cycle(PH_DECODE,  2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "midrst");
        cycle(PH_MEMADR,  2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "midrst");
        cycle(PH_MEMREAD, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "midrst");
        do_reset("midrst_reset");
        run_instr(2'b00, 1'b1, 1'b0, 1'b1, 0, 0, "midrst_after");

        // ready on the last allowed stall wins over the timeout
        run_instr(2'b01, 1'b0, 1'b1, 1'b1, WAIT_MAX - 1, WAIT_MAX - 1, "ready_wins");

        // timeouts in each waiting state
        run_instr(2'b01, 1'b0, 1'b0, 1'b1, 0, WAIT_MAX, "store_timeout");
        run_instr(2'b00, 1'b0, 1'b0, 1'b1, 0, 0, "after_store_to");
        do_reset("reset_to1");
        run_instr(2'b01, 1'b0, 1'b1, 1'b1, 0, WAIT_MAX, "load_timeout");
        run_instr(2'b10, 1'b0, 1'b0, 1'b1, 0, 0, "after_load_to");
        do_reset("reset_to2");
        run_instr(2'b00, 1'b0, 1'b0, 1'b1, WAIT_MAX, 0, "fetch_timeout");
        run_instr(2'b00, 1'b0, 1'b0, 1'b1, WAIT_MAX, 0, "fetch_timeout2");
        run_instr(2'b00, 1'b0, 1'b0, 1'b1, 2, 0, "after_fetch_to");

        // random stream, long enough to saturate the cycle counter
        do_reset("reset_rand");
        for (int n = 0; n < 90; n++) begin
            run_instr(2'($urandom_range(0, 3)), rnd_bit(), rnd_bit(), rnd_bit(),
                      int'($urandom_range(0, WAIT_MAX - 1)), int'($urandom_range(0, WAIT_MAX - 1)),
                      "rand");
        end
        check("cycle_cnt_sat", 32'(cycle_cnt), cnt_exp(m_cyc));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
